// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump redirect and pipeline flush control.
// Optional macro BRANCH_STATS_EN adds saturating branch/taken statistics counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_pc_plus4,
  input  logic [15:0] ex_immediate,
  input  logic [25:0] ex_instr_index,
  input  logic        sig_branch,
`ifdef BRANCH_STATS_EN
  output logic [31:0] branch_count,
  output logic [31:0] taken_count,
`endif
  output logic [31:0] pc,
  output logic        redirect,
  output logic        flush_if_id,
  output logic        flush_id_ex
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic        redirect_nxt;
  logic        flush, flush_nxt;

  logic        is_br, is_j, take;
  logic signed [31:0] br_offset;
  logic [31:0] br_target, j_target, target, pc_seq;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign is_br     = (ex_opcode == OP_BEQ) || (ex_opcode == OP_BNE);
  assign is_j      = (ex_opcode == OP_J);
  assign take      = ex_valid & ((is_br & sig_branch) | is_j);

  assign br_offset = {{14{ex_immediate[15]}}, ex_immediate, 2'b00};
  assign br_target = ex_pc_plus4 + br_offset;
  assign j_target  = {ex_pc_plus4[31:28], ex_instr_index, 2'b00};
  assign target    = is_j ? j_target : br_target;
  // Sequential fetch address; stall holds the current PC
  assign pc_seq    = stall ? pc : pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 2'd0;
      pc       <= RESET_PC;
      redirect <= 1'b0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
      flush    <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_nxt       = pc_seq;
    redirect_nxt = 1'b0;
    flush_nxt    = flush;
    case (state)
      RUN: begin
        if (take) begin
          // Redirect wins over stall: the target must load now
          pc_nxt       = target;
          redirect_nxt = 1'b1;
          flush_nxt    = 1'b1;
          cnt_nxt      = 2'(FLUSH_CYCLES - 1);
          state_nxt    = FLUSH;
        end else begin
          flush_nxt = 1'b0;
        end
      end
      FLUSH: begin
        // Counter runs even under stall so the flush window is fixed length
        if (cnt == 2'd0) begin
          flush_nxt = 1'b0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush_if_id = flush;
  assign flush_id_ex = flush;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count <= 32'd0;
      taken_count  <= 32'd0;
    end else if (state == RUN && ex_valid && is_br) begin
      branch_count <= sat_inc(branch_count);
      if (sig_branch)
        taken_count <= sat_inc(taken_count);
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit (default parameters).
// Build with BRANCH_STATS_EN defined to also exercise the statistics counters.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, sig_branch;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_pc_plus4;
  logic [15:0] ex_immediate;
  logic [25:0] ex_instr_index;
  logic [31:0] pc;
  logic        redirect, flush_if_id, flush_id_ex;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count, taken_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_immediate   (ex_immediate),
    .ex_instr_index (ex_instr_index),
    .sig_branch     (sig_branch),
`ifdef BRANCH_STATS_EN
    .branch_count   (branch_count),
    .taken_count    (taken_count),
`endif
    .pc             (pc),
    .redirect       (redirect),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Advance one clock, then check pc, redirect and both flushes
  task automatic step(input string tag, input logic [31:0] epc, input logic er, input logic ef);
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, er});
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, ef});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, ef});
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic sb,
                       input logic [31:0] p4, input logic [15:0] imm, input logic [25:0] idx);
    ex_valid       = v;
    ex_opcode      = op;
    sig_branch     = sb;
    ex_pc_plus4    = p4;
    ex_immediate   = imm;
    ex_instr_index = idx;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);

    // Reset and sequential fetch
    step("rst0", 32'h0, 1'b0, 1'b0);
    step("rst1", 32'h0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("rst.branch_count", branch_count, 32'd0);
    chk("rst.taken_count", taken_count, 32'd0);
`endif
    rst = 1'b0;
    step("seq1", 32'h4, 1'b0, 1'b0);
    step("seq2", 32'h8, 1'b0, 1'b0);
    step("seq3", 32'hC, 1'b0, 1'b0);

    // BEQ not taken
    drive(1'b1, 6'b000100, 1'b0, 32'h10, 16'd3, 26'd0);
    step("beq_nt", 32'h10, 1'b0, 1'b0);

    // BEQ taken; take held high during the flush window is ignored
    drive(1'b1, 6'b000100, 1'b1, 32'h10, 16'd3, 26'd0);
    step("beq_t", 32'h1C, 1'b1, 1'b1);
    step("beq_fl2", 32'h20, 1'b0, 1'b1);
    step("beq_fl_end", 32'h24, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stats.branch_count", branch_count, 32'd2);
    chk("stats.taken_count", taken_count, 32'd1);
`endif

    // Negative offset
    drive(1'b1, 6'b000100, 1'b1, 32'h100, 16'hFFFE, 26'd0);
    step("neg_t", 32'hF8, 1'b1, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("neg_fl2", 32'hFC, 1'b0, 1'b1);
    step("neg_end", 32'h100, 1'b0, 1'b0);

    // Target wraps below zero, then pc+4 wraps to zero
    drive(1'b1, 6'b000100, 1'b1, 32'h4, 16'hFFFE, 26'd0);
    step("wrap_t", 32'hFFFF_FFFC, 1'b1, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("wrap0", 32'h0, 1'b0, 1'b1);
    step("wrap4", 32'h4, 1'b0, 1'b0);

    // Jump with stall in the same cycle
    stall = 1'b1;
    drive(1'b1, 6'b000010, 1'b0, 32'h4000_0010, 16'd0, 26'h40);
    step("jmp", 32'h4000_0100, 1'b1, 1'b1);
    stall = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("jmp_fl2", 32'h4000_0104, 1'b0, 1'b1);
    step("jmp_end", 32'h4000_0108, 1'b0, 1'b0);

    // Stall in RUN holds pc
    stall = 1'b1;
    step("stall1", 32'h4000_0108, 1'b0, 1'b0);
    step("stall2", 32'h4000_0108, 1'b0, 1'b0);
    step("stall3", 32'h4000_0108, 1'b0, 1'b0);
    stall = 1'b0;

    // BNE taken, then stall during flush: flush window length is unchanged
    drive(1'b1, 6'b000101, 1'b1, 32'h200, 16'd0, 26'd0);
    step("bne_t", 32'h200, 1'b1, 1'b1);
    stall = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("bne_fl_stall", 32'h200, 1'b0, 1'b1);
    step("bne_end_stall", 32'h200, 1'b0, 1'b0);
    stall = 1'b0;

    // sig_branch ignored for non-branch opcodes and for invalid EX slots
    drive(1'b1, 6'b000000, 1'b1, 32'h800, 16'd5, 26'd0);
    step("alu_op", 32'h204, 1'b0, 1'b0);
    drive(1'b0, 6'b000100, 1'b1, 32'h800, 16'd5, 26'd0);
    step("invalid", 32'h208, 1'b0, 1'b0);

    // Reset during the first flush cycle
    drive(1'b1, 6'b000100, 1'b1, 32'h300, 16'd1, 26'd0);
    step("rstfl_t", 32'h304, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("rstfl_rst", 32'h0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("rstfl.branch_count", branch_count, 32'd0);
    chk("rstfl.taken_count", taken_count, 32'd0);
`endif
    rst = 1'b0;
    step("rstfl_run", 32'h4, 1'b0, 1'b0);
    // A take right away must be honoured, showing the FSM is in RUN
    drive(1'b1, 6'b000010, 1'b0, 32'h8, 16'd0, 26'h10);
    step("rstfl_jmp", 32'h40, 1'b1, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 32'd0, 16'd0, 26'd0);
    step("rstfl_fl2", 32'h44, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Fetch PC register and branch/jump redirect controller; sits directly downstream of the ALU and consumes its sig_branch compare result.
- Tracks the EX-stage instruction: opcode, PC+4, immediate and jump index.
- Steers the fetch PC to the branch/jump target.
- Drives pipeline flush for the squashed younger instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word-aligned.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect; legal 1..3.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold; PC does not advance.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_opcode  in  6  opcode of EX instruction (same value driven to ALU opcode).
- ex_pc_plus4  in  32  PC+4 of EX instruction.
- ex_immediate  in  16  I-type immediate of EX instruction.
- ex_instr_index  in  26  J-type target field of EX instruction.
- sig_branch  in  1  ALU branch condition satisfied (combinational from ALU).
- pc  out  32  current fetch PC (registered).
- redirect  out  1  one-cycle pulse: PC was just loaded with a target.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.

Behaviour:
Reset values:
- rst=1 at a clock edge: pc=RESET_PC, state=RUN, redirect=0, flush_if_id=0, flush_id_ex=0, flush counter=0.
- Reset overrides everything, including a flush in progress: next state is RUN with flushes low.

Decode (combinational):
- is_br = ex_opcode is 6'b000100 (BEQ) or 6'b000101 (BNE).
- is_j = ex_opcode is 6'b000010 (J).
- The ALU sets sig_branch = "condition met" for both BEQ and BNE.
- take = ex_valid & ((is_br & sig_branch) | is_j). sig_branch is ignored for J and for all other opcodes.

Targets:
- Branch target = ex_pc_plus4 + {sext(ex_immediate),2'b00}, computed in 32 bits, modulo 2^32 (wraps).
- Jump target = {ex_pc_plus4[31:28], ex_instr_index, 2'b00}.
- Target bits [1:0] are always 00.

FSM, two states, RUN and FLUSH:
- RUN, take=1: pc<=target; redirect<=1; flush_if_id<=1; flush_id_ex<=1; cnt<=FLUSH_CYCLES-1; state<=FLUSH. A redirect overrides stall.
- RUN, take=0: pc<=pc+4 if stall=0, else pc holds. Flushes and redirect <=0.
- FLUSH: redirect<=0; take is ignored (the EX slot is being squashed).
  - pc<=pc+4 unless stall=1.
  - cnt=0: flushes<=0, state<=RUN; otherwise cnt<=cnt-1.
  - cnt decrements every cycle, regardless of stall.

Latency and timing:
- Redirect latency is one cycle: target appears on pc the cycle after take is sampled.
- flush_if_id and flush_id_ex are high for exactly FLUSH_CYCLES consecutive cycles.
- redirect is high only in the first of those cycles.
- pc+4 wraps from 0xFFFFFFFC to 0x00000000.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs branch_count [31:0] and taken_count [31:0], reset to 0.
  - In RUN, each cycle with ex_valid & is_br increments branch_count.
  - If that branch is also taken, taken_count increments.
  - J and the FLUSH state are not counted.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset and sequential fetch: rst=1 for 2 cycles, then stall=0 and ex_valid=0 for 3 cycles -> pc=0, 4, 8, 12; redirect and flushes stay 0.
- BEQ not taken (ALU rs=15, rt=12): opcode 000100, sig_branch=0, ex_pc_plus4=0x10, imm=3 -> no redirect; pc keeps incrementing by 4.
- BEQ taken (rs=15, rt=15): sig_branch=1, ex_pc_plus4=0x10, imm=3:
  - next cycle pc=0x1C, redirect=1 for 1 cycle, flushes=1 for 2 cycles.
  - A second take asserted in the following cycle is ignored.
- Negative offset and wrap:
  - ex_pc_plus4=0x100, imm=0xFFFE -> pc=0xF8.
  - ex_pc_plus4=0x4, imm=0xFFFE -> pc=0xFFFFFFFC.
  - Then 2 free cycles with no stall -> pc=0x0, then 0x4.
- J with stall=1 in the same cycle: ex_pc_plus4=0x40000010, index=0x0000040, sig_branch=0 -> pc=0x40000100, redirect=1.
- Stall and reset mid-flush:
  - stall=1 for 3 cycles in RUN -> pc holds.
  - Take a branch, then assert rst during the first FLUSH cycle -> next cycle pc=RESET_PC, flushes=0, state RUN.
  - With BRANCH_STATS_EN defined, after scenarios 2 and 3: branch_count=2, taken_count=1.
